// File: rtl/load_unit.sv
// Execute-stage load unit: forms the effective address, performs one word read over a
// valid/ready memory port, extracts and extends the addressed lane, and issues a writeback.
module load_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [4:0]      load_control,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [11:0]     imm,
   input  logic [4:0]      rd,
   output logic            busy,
   output logic            mem_req_valid,
   input  logic            mem_req_ready,
   output logic [XLEN-1:0] mem_addr,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            wb_valid,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            misaligned
);

   // Load-control encodings shared with the decoder (processor_defines.sv).
   localparam logic [4:0] LD_NOP = 5'b00000;
   localparam logic [4:0] LB     = 5'b00001;
   localparam logic [4:0] LH     = 5'b00010;
   localparam logic [4:0] LW     = 5'b00100;
   localparam logic [4:0] LBU    = 5'b01000;
   localparam logic [4:0] LHU    = 5'b10000;

   typedef enum logic [2:0] {IDLE, REQ, RESP, WB, FAULT} state_t;

   state_t          state;
   logic [1:0]      lane_p0;
   logic [4:0]      rd_p0;
   logic [4:0]      ctrl_p0;
   logic [XLEN-1:0] ea;

   assign ea = rs1_data + {{(XLEN-12){imm[11]}}, imm};

   function automatic logic is_load(input logic [4:0] c);
      return (c == LB) || (c == LH) || (c == LW) || (c == LBU) || (c == LHU);
   endfunction

   function automatic logic is_misaligned(input logic [4:0] c, input logic [1:0] lane);
      logic m;
      m = 1'b0;
      case (c)
         LH, LHU: m = lane[0];
         LW:      m = (lane != 2'b00);
         default: m = 1'b0;
      endcase
      return m;
   endfunction

   function automatic logic [XLEN-1:0] extract(input logic [4:0] c, input logic [1:0] lane,
                                               input logic [XLEN-1:0] word);
      logic [XLEN-1:0]    shifted;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic [XLEN-1:0]    r;
      shifted = word >> {lane, 3'b000};
      b       = shifted[7:0];
      h       = lane[1] ? word[31:16] : word[15:0];
      case (c)
         LB:      r = {{(XLEN-8){b[7]}}, b};
         LBU:     r = {{(XLEN-8){1'b0}}, b};
         LH:      r = {{(XLEN-16){h[15]}}, h};
         LHU:     r = {{(XLEN-16){1'b0}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         busy          <= 1'b0;
         mem_req_valid <= 1'b0;
         wb_valid      <= 1'b0;
         misaligned    <= 1'b0;
         mem_addr      <= '0;
         wb_rd         <= '0;
         wb_data       <= '0;
         lane_p0       <= '0;
         rd_p0         <= '0;
         ctrl_p0       <= LD_NOP;
      end else begin
         case (state)
            // Capture: anything that is not a real load leaves the unit idle.
            IDLE: begin
               if (start) begin
                  lane_p0  <= ea[1:0];
                  rd_p0    <= rd;
                  ctrl_p0  <= load_control;
                  mem_addr <= {ea[XLEN-1:2], 2'b00};
                  if (is_load(load_control)) begin
                     busy <= 1'b1;
                     if (is_misaligned(load_control, ea[1:0])) begin
                        misaligned <= 1'b1;
                        state      <= FAULT;
                     end else begin
                        mem_req_valid <= 1'b1;
                        state         <= REQ;
                     end
                  end
               end
            end
            // Request: address held until the handshake; a response here is too early.
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  state         <= RESP;
               end
            end
            // Response: writes to x0 still complete but never strobe.
            RESP: begin
               if (mem_rsp_valid) begin
                  if (rd_p0 != 5'd0) begin
                     wb_valid <= 1'b1;
                     wb_rd    <= rd_p0;
                     wb_data  <= extract(ctrl_p0, lane_p0, mem_rdata);
                  end
                  state <= WB;
               end
            end
            WB: begin
               wb_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            FAULT: begin
               misaligned <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_unit.sv
// Randomized and directed bench for load_unit; the bench plays the data memory and compares
// every transaction against an arithmetic model of the load semantics.
module tb_load_unit;

   localparam logic [4:0] LD_NOP = 5'b00000;
   localparam logic [4:0] LB     = 5'b00001;
   localparam logic [4:0] LH     = 5'b00010;
   localparam logic [4:0] LW     = 5'b00100;
   localparam logic [4:0] LBU    = 5'b01000;
   localparam logic [4:0] LHU    = 5'b10000;
   localparam logic [4:0] LD_BAD = 5'b00011;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [4:0]  load_control = LD_NOP;
   logic [31:0] rs1_data = '0;
   logic [11:0] imm = '0;
   logic [4:0]  rd = '0;
   logic        busy, mem_req_valid, wb_valid, misaligned;
   logic        mem_req_ready = 1'b0;
   logic        mem_rsp_valid = 1'b0;
   logic [31:0] mem_addr, wb_data;
   logic [31:0] mem_rdata = '0;
   logic [4:0]  wb_rd;

   int n_checks = 0;
   int n_fail   = 0;

   logic [4:0]  last_rd   = '0;
   logic [31:0] last_data = '0;

   bit          o_req_seen, o_addr_moved, o_timeout;
   logic [31:0] o_addr, o_wb_data;
   logic [4:0]  o_wb_rd;
   int          o_wb_cnt, o_wb_cyc, o_mis_cnt, o_mis_cyc, o_busy_cnt;

   load_unit #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .start(start), .load_control(load_control),
      .rs1_data(rs1_data), .imm(imm), .rd(rd), .busy(busy),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
      .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
      .wb_rd(wb_rd), .wb_data(wb_data), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_ea(input logic [31:0] base, input logic [11:0] off);
      int signed_off;
      signed_off = $signed(off);
      return base + signed_off;
   endfunction

   function automatic bit ref_is_load(input logic [4:0] c);
      return (c == LB) || (c == LH) || (c == LW) || (c == LBU) || (c == LHU);
   endfunction

   function automatic bit ref_misaligned(input logic [4:0] c, input logic [31:0] ea);
      return ((c == LW) && (ea % 4 != 0)) || (((c == LH) || (c == LHU)) && (ea % 2 != 0));
   endfunction

   function automatic logic [31:0] ref_result(input logic [4:0] c, input logic [31:0] ea,
                                              input logic [31:0] word);
      logic [31:0] sh;
      int          v;
      sh = word >> (8 * (ea % 4));
      case (c)
         LB:      begin v = $signed(sh[7:0]);  return v; end
         LH:      begin v = $signed(sh[15:0]); return v; end
         LBU:     return sh & 32'h0000_00FF;
         LHU:     return sh & 32'h0000_FFFF;
         default: return word;
      endcase
   endfunction

   // Issues one start and plays memory until the unit goes idle again; records what it saw.
   task automatic do_load(input logic [31:0] base, input logic [11:0] off, input logic [4:0] ctl,
                          input logic [4:0] dst, input logic [31:0] word, input int rdy_dly,
                          input int rsp_dly, input bit early_rsp, input bit hold_start);
      int cyc, phase, req_wait, rsp_wait;
      logic [31:0] ea;
      ea = ref_ea(base, off);
      start = 1'b1; load_control = ctl; rs1_data = base; imm = off; rd = dst;
      o_req_seen = 0; o_addr_moved = 0; o_timeout = 0; o_addr = '0; o_wb_data = '0;
      o_wb_rd = '0; o_wb_cnt = 0; o_wb_cyc = 0; o_mis_cnt = 0; o_mis_cyc = 0; o_busy_cnt = 0;
      phase = 0; req_wait = 0; rsp_wait = 0; cyc = 1;
      @(posedge clk); #1;
      start = 1'b0;
      rs1_data = $urandom; imm = 12'($urandom); rd = 5'($urandom); load_control = LW;
      while (cyc < 80) begin
         if (busy) o_busy_cnt++;
         if (misaligned) begin o_mis_cnt++; o_mis_cyc = cyc; end
         if (wb_valid) begin o_wb_cnt++; o_wb_rd = wb_rd; o_wb_data = wb_data; o_wb_cyc = cyc; end
         mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; start = 1'b0;
         if (!busy && (o_busy_cnt > 0 || cyc >= 3)) break;
         start = hold_start && busy;
         if (mem_req_valid) begin
            if (!o_req_seen) o_addr = mem_addr;
            else if (mem_addr !== o_addr) o_addr_moved = 1;
            o_req_seen = 1;
            if (req_wait >= rdy_dly) begin
               mem_req_ready = 1'b1;
               phase = 1;
               if (early_rsp) begin mem_rsp_valid = 1'b1; mem_rdata = ~word; end
            end else req_wait++;
         end else if (phase == 1) begin
            if (rsp_wait >= rsp_dly) begin
               mem_rsp_valid = 1'b1; mem_rdata = word; phase = 2;
            end else rsp_wait++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (cyc >= 80) o_timeout = 1;
      if (ref_is_load(ctl) && !ref_misaligned(ctl, ea) && dst != 0) begin
         last_rd = dst; last_data = ref_result(ctl, ea, word);
      end
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({busy, mem_req_valid, wb_valid, misaligned} !== 4'b0 || mem_addr !== 0 || wb_rd !== 0 || wb_data !== 0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b req=%b wb=%b mis=%b addr=%h rd=%0d data=%h, required all zero",
                  busy, mem_req_valid, wb_valid, misaligned, mem_addr, wb_rd, wb_data);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_extract();
      do_load(32'h1000, 12'h003, LB, 5'd5, 32'h80FF_1234, 0, 0, 0, 0);
      n_checks++;
      if (o_addr !== 32'h1000 || o_wb_cyc != 3 || o_wb_rd !== 5'd5 || o_wb_data !== 32'hFFFF_FF80 || o_busy_cnt != 3) begin
         n_fail++;
         $display("FAIL lb_lane3: addr=%h wbcyc=%0d rd=%0d data=%h busycyc=%0d, required 1000/3/5/ffffff80/3",
                  o_addr, o_wb_cyc, o_wb_rd, o_wb_data, o_busy_cnt);
      end
      do_load(32'h1000, 12'h003, LBU, 5'd6, 32'h80FF_1234, 0, 0, 0, 0);
      n_checks++;
      if (o_wb_data !== 32'h0000_0080 || o_wb_cnt != 1) begin
         n_fail++; $display("FAIL lbu_lane3: data=%h cnt=%0d, required 00000080/1", o_wb_data, o_wb_cnt);
      end
      do_load(32'h2000, 12'h002, LHU, 5'd7, 32'hBEEF_0000, 0, 0, 0, 0);
      n_checks++;
      if (o_wb_data !== 32'h0000_BEEF || o_addr !== 32'h2000) begin
         n_fail++; $display("FAIL lhu_upper: data=%h addr=%h, required 0000beef/2000", o_wb_data, o_addr);
      end
      do_load(32'h2000, 12'h002, LH, 5'd8, 32'hBEEF_0000, 0, 0, 0, 0);
      n_checks++;
      if (o_wb_data !== 32'hFFFF_BEEF || o_wb_rd !== 5'd8) begin
         n_fail++; $display("FAIL lh_upper: data=%h rd=%0d, required ffffbeef/8", o_wb_data, o_wb_rd);
      end
   endtask

   task automatic test_stall();
      do_load(32'h0000_0010, 12'hFFC, LW, 5'd9, 32'hCAFE_F00D, 3, 2, 1, 0);
      n_checks++;
      if (o_addr !== 32'h0000_000C || o_addr_moved || o_wb_cnt != 1 || o_wb_cyc != 8 || o_wb_data !== 32'hCAFE_F00D) begin
         n_fail++;
         $display("FAIL lw_stall: addr=%h moved=%0d wbcnt=%0d wbcyc=%0d data=%h, required 0000000c/0/1/8/cafef00d",
                  o_addr, o_addr_moved, o_wb_cnt, o_wb_cyc, o_wb_data);
      end
   endtask

   task automatic test_misaligned();
      do_load(32'h1000, 12'h002, LW, 5'd3, 32'h1111_1111, 0, 0, 0, 0);
      n_checks++;
      if (o_mis_cnt != 1 || o_mis_cyc != 1 || o_req_seen || o_wb_cnt != 0 || o_busy_cnt != 1) begin
         n_fail++;
         $display("FAIL lw_misaligned: mis=%0d@%0d req=%0d wb=%0d busy=%0d, required 1@1/0/0/1",
                  o_mis_cnt, o_mis_cyc, o_req_seen, o_wb_cnt, o_busy_cnt);
      end
      do_load(32'h1000, 12'h001, LH, 5'd3, 32'h1111_1111, 0, 0, 0, 0);
      n_checks++;
      if (o_mis_cnt != 1 || o_req_seen || o_wb_cnt != 0) begin
         n_fail++;
         $display("FAIL lh_misaligned: mis=%0d req=%0d wb=%0d, required 1/0/0", o_mis_cnt, o_req_seen, o_wb_cnt);
      end
   endtask

   task automatic test_ignored_starts();
      do_load(32'h3000, 12'h000, LW, 5'd12, 32'h1234_5678, 1, 1, 0, 1);
      n_checks++;
      if (o_wb_cnt != 1 || o_wb_rd !== 5'd12 || o_wb_data !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL start_while_busy: wbcnt=%0d rd=%0d data=%h, required 1/12/12345678", o_wb_cnt, o_wb_rd, o_wb_data);
      end
      do_load(32'h3000, 12'h000, LD_NOP, 5'd13, 32'h0, 0, 0, 0, 0);
      n_checks++;
      if (o_req_seen || o_wb_cnt != 0 || o_busy_cnt != 0 || o_mis_cnt != 0) begin
         n_fail++;
         $display("FAIL ld_nop: req=%0d wb=%0d busy=%0d mis=%0d, required all 0", o_req_seen, o_wb_cnt, o_busy_cnt, o_mis_cnt);
      end
      do_load(32'h3000, 12'h000, LD_BAD, 5'd13, 32'h0, 0, 0, 0, 0);
      n_checks++;
      if (o_req_seen || o_wb_cnt != 0 || o_busy_cnt != 0) begin
         n_fail++;
         $display("FAIL undefined_ctrl: req=%0d wb=%0d busy=%0d, required all 0", o_req_seen, o_wb_cnt, o_busy_cnt);
      end
      do_load(32'h4000, 12'h004, LW, 5'd0, 32'hDEAD_BEEF, 0, 0, 0, 0);
      n_checks++;
      if (!o_req_seen || o_addr !== 32'h4004 || o_wb_cnt != 0 || o_busy_cnt != 3 || wb_rd !== 5'd12 || wb_data !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL rd_zero: req=%0d addr=%h wb=%0d busy=%0d hold_rd=%0d hold_data=%h, required 1/4004/0/3/12/12345678",
                  o_req_seen, o_addr, o_wb_cnt, o_busy_cnt, wb_rd, wb_data);
      end
   endtask

   task automatic test_reset_mid();
      int seen_wb, seen_busy;
      start = 1'b1; load_control = LW; rs1_data = 32'h5000; imm = 12'h0; rd = 5'd4;
      @(posedge clk); #1 start = 1'b0; mem_req_ready = 1'b1;
      @(posedge clk); #1 mem_req_ready = 1'b0;
      #3 rst = 1'b1;
      #1;
      n_checks++;
      if ({busy, mem_req_valid, wb_valid, misaligned} !== 4'b0 || mem_addr !== 0 || wb_rd !== 0 || wb_data !== 0) begin
         n_fail++;
         $display("FAIL async_reset_mid: busy=%b req=%b wb=%b mis=%b addr=%h rd=%0d data=%h, required all zero",
                  busy, mem_req_valid, wb_valid, misaligned, mem_addr, wb_rd, wb_data);
      end
      last_rd = '0; last_data = '0;
      @(posedge clk); #1 rst = 1'b0; mem_rsp_valid = 1'b1; mem_rdata = 32'hAAAA_5555;
      seen_wb = 0; seen_busy = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 mem_rsp_valid = 1'b0;
         if (wb_valid) seen_wb++;
         if (busy) seen_busy++;
      end
      n_checks++;
      if (seen_wb != 0 || seen_busy != 0) begin
         n_fail++; $display("FAIL late_response: wb=%0d busy=%0d, required 0/0", seen_wb, seen_busy);
      end
      do_load(32'h5000, 12'h001, LBU, 5'd4, 32'h0000_7700, 0, 0, 0, 0);
      n_checks++;
      if (o_wb_cnt != 1 || o_wb_data !== 32'h0000_0077 || o_wb_cyc != 3) begin
         n_fail++;
         $display("FAIL after_reset: wbcnt=%0d data=%h cyc=%0d, required 1/00000077/3", o_wb_cnt, o_wb_data, o_wb_cyc);
      end
   endtask

   task automatic test_random();
      logic [4:0]  ctl_tab [7] = '{LB, LH, LW, LBU, LHU, LD_NOP, LD_BAD};
      logic [31:0] base, word, ea, exp_data;
      logic [11:0] off;
      logic [4:0]  ctl, dst;
      int          rdy, rsp, exp_busy;
      bit          ld, mis, exp_wb;
      for (int t = 0; t < 60; t++) begin
         base = $urandom; off = 12'($urandom); word = $urandom;
         ctl = ctl_tab[$urandom_range(0, 6)]; dst = 5'($urandom);
         rdy = $urandom_range(0, 3); rsp = $urandom_range(0, 3);
         ea = ref_ea(base, off);
         ld = ref_is_load(ctl); mis = ld && ref_misaligned(ctl, ea);
         exp_wb = ld && !mis && dst != 0;
         exp_data = ref_result(ctl, ea, word);
         exp_busy = !ld ? 0 : (mis ? 1 : 3 + rdy + rsp);
         do_load(base, off, ctl, dst, word, rdy, rsp, 1'($urandom_range(0, 1)), 0);
         n_checks++;
         if (o_timeout || o_busy_cnt != exp_busy || o_mis_cnt != int'(mis) || o_req_seen != (ld && !mis)) begin
            n_fail++;
            $display("FAIL rand_ctrl[%0d]: timeout=%0d busy=%0d mis=%0d req=%0d, required 0/%0d/%0d/%0d (ctl=%b ea=%h)",
                     t, o_timeout, o_busy_cnt, o_mis_cnt, o_req_seen, exp_busy, mis, ld && !mis, ctl, ea);
         end
         if (o_req_seen) begin
            n_checks++;
            if (o_addr !== {ea[31:2], 2'b00} || o_addr_moved) begin
               n_fail++;
               $display("FAIL rand_addr[%0d]: addr=%h moved=%0d, required %h/0", t, o_addr, o_addr_moved, {ea[31:2], 2'b00});
            end
         end
         n_checks++;
         if (o_wb_cnt != int'(exp_wb) || (exp_wb && (o_wb_rd !== dst || o_wb_data !== exp_data || o_wb_cyc != 3 + rdy + rsp))) begin
            n_fail++;
            $display("FAIL rand_wb[%0d]: cnt=%0d rd=%0d data=%h cyc=%0d, required %0d/%0d/%h/%0d (ctl=%b ea=%h word=%h)",
                     t, o_wb_cnt, o_wb_rd, o_wb_data, o_wb_cyc, exp_wb, dst, exp_data, 3 + rdy + rsp, ctl, ea, word);
         end
         n_checks++;
         if (wb_rd !== last_rd || wb_data !== last_data) begin
            n_fail++;
            $display("FAIL rand_hold[%0d]: wb_rd=%0d wb_data=%h, required %0d/%h", t, wb_rd, wb_data, last_rd, last_data);
         end
      end
   endtask

   initial begin
      test_reset();
      @(posedge clk); #1;
      test_extract();
      test_stall();
      test_misaligned();
      test_ignored_starts();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Execute-stage consumer of the load-class decoder output (rs1, rd, 12-bit imm, 5-bit load control).
- Computes the effective address, issues one word read on a valid/ready data-memory port and waits for the response.
- Extracts, sign- or zero-extends the addressed byte/halfword/word, then presents a single-cycle register writeback.
- Sits between the load decoder/register file and the data memory.

Parameters:
- XLEN, 32, data/address width (only 32 supported)

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  issue request; sampled only when busy=0
- load_control  input  5  `LB/`LH/`LW/`LBU/`LHU/`LD_NOP encodings from processor_defines.sv
- rs1_data  input  XLEN  base register value
- imm  input  12  signed offset
- rd  input  5  destination register
- busy  output  1  high from the cycle after an accepted start until the cycle after wb_valid/misaligned
- mem_req_valid  output  1  read request valid
- mem_req_ready  input  1  memory accepts request
- mem_addr  output  XLEN  word-aligned address, bits [1:0]=0
- mem_rsp_valid  input  1  read data valid
- mem_rdata  input  XLEN  read word, little-endian
- wb_valid  output  1  one-cycle writeback strobe
- wb_rd  output  5  writeback register
- wb_data  output  XLEN  extended load result
- misaligned  output  1  one-cycle misaligned-address pulse

Behaviour:
- Reset (async, immediate): state=IDLE; busy, mem_req_valid, wb_valid and misaligned=0; mem_addr, wb_rd and wb_data=0.
- Reset mid-transaction aborts it. A pending memory response arriving after reset deasserts is ignored in IDLE.
- Effective address: ea = rs1_data + sign_extend(imm), modulo 2^32 (wraps, no overflow flag).
- Capture: on start && !busy, latch ea[1:0], rd and load_control. mem_addr <= {ea[31:2],2'b00}.
- start while busy=1 is ignored (no queueing).
- States and transitions:
  - IDLE: on start with `LD_NOP or any undefined control, stay in IDLE; busy stays 0; no request, no writeback.
  - IDLE: on a misaligned load (LH/LHU with ea[0]=1; LW with ea[1:0]!=0), go to FAULT.
  - IDLE: otherwise go to REQ.
  - FAULT: misaligned=1 for exactly one cycle; no memory access, no writeback; return to IDLE.
  - REQ: mem_req_valid=1 and mem_addr held stable until mem_req_ready=1 (handshake cycle); then go to RESP.
  - RESP: wait any number of cycles for mem_rsp_valid. mem_rsp_valid in the REQ handshake cycle is not accepted. On mem_rsp_valid, latch the extracted result and go to WB.
  - WB: wb_valid=1 for one cycle with wb_rd/wb_data; return to IDLE.
- Extraction:
  - Byte lane = ea[1:0] (lane 0 = bits[7:0]).
  - Halfword lane = ea[1] (0 = bits[15:0]).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- rd=0: the transaction runs fully; wb_valid stays 0 in WB.
- wb_rd/wb_data hold their last values when wb_valid=0.
- Minimum latency, with ready and response immediate:
  - start at cycle N; mem_req_valid at N+1; response at N+2; wb_valid at N+3.
  - busy is high N+1..N+3 and low at N+4.
- A new start is accepted on the first cycle busy=0.

Test Plan:
- rs1=0x1000, imm=0x003, LB, rd=5, mem_rdata=0x80FF_1234 (ready/rsp immediate) -> mem_addr=0x1000; wb_valid at start+3 with wb_rd=5, wb_data=0xFFFF_FF80.
- Same address with LBU -> wb_data=0x0000_0080. rs1=0x2000, imm=0x002, LHU with mem_rdata=0xBEEF_0000 -> wb_data=0x0000_BEEF; LH -> wb_data=0xFFFF_BEEF.
- rs1=0x0000_0010, imm=0xFFC (-4), LW, ready held 0 for 3 cycles then 1, rsp 2 cycles later -> mem_req_valid and mem_addr=0x0000_000C stable throughout; exactly one writeback.
- LW with ea=0x1002, then LH with ea=0x1001 -> misaligned one-cycle pulse each, mem_req_valid never asserted, wb_valid=0.
- Second start while busy, then `LD_NOP start when idle -> both produce no request and no writeback. rd=0 LW -> memory read occurs, wb_valid stays 0.
- Assert rst during RESP -> all outputs 0 immediately; a late mem_rsp_valid is ignored; a subsequent start runs normally.
